weighted_rr_arbiter: RTL
========================

# weighted_rr_arbiter

Parametrised weighted round-robin arbiter with a registered one-hot grant. Each requester holds the grant for up to `weight[i]` completed transfers before priority rotates, and a requester that drops its request releases the grant early. Winner changes are back-to-back, with no idle cycle between owners. It sits in front of a shared resource (bus, memory port, output queue) and replaces the single-cycle round-robin arbiter wherever requesters need burst fairness.

## Interface
Parameters:
- `request_lines`, default 4: number of requesters N; N ≥ 2.
- `WEIGHT_W`, default 4: width W of each per-requester weight field.

Ports:
- `clk`, in, 1: clock. Everything is on the rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `req`, in, N: request vector. Bit i is held high while requester i wants the resource.
- `weight`, in, N*W: weight of requester i is `weight[i*W +: W]`.
  - Sampled only when i is granted.
  - A value of 0 is treated as 1.
- `done`, in, 1: the current owner completed one transfer this cycle. Ignored when `grant_valid` = 0.
- `grant`, out, N: registered one-hot grant, or all-zero.
- `grant_idx`, out, clog2(N): binary index of the owner. Holds its last value when `grant_valid` = 0.
- `grant_valid`, out, 1: equals OR of `grant`.
- `credit`, out, W: transfers remaining for the current owner, including the current one.

## Operation
State:
- FSM with two states, IDLE and OWNED.
- Rotate pointer `ptr`: index of the last owner.
- Credit counter: W bits.

Reset:
- `grant` = 0, `grant_valid` = 0, `grant_idx` = 0, `credit` = 0.
- `ptr` = N-1, so requester 0 has highest priority first.
- FSM = IDLE.

Arbitration function (combinational):
- Input is a candidate vector.
- Search order is `ptr`+1, `ptr`+2, … wrapping modulo N.
- The current `ptr` index is searched last.
- Output is the first set bit.
- Implement as masked/unmasked priority pick: mask = bits above `ptr`; if the masked vector is zero, use the unmasked vector.

IDLE:
- If `req` ≠ 0: pick winner w from `req`.
- At the edge: `grant` ← onehot(w), `grant_idx` ← w, `ptr` ← w, `credit` ← max(`weight[w]`, 1). Go to OWNED.

OWNED, owner o. The first matching rule wins:
1. `req[o]` = 0 (abandon): rearbitrate over `req`; o is not a candidate.
2. `done` = 1 and `credit` = 1 (weight exhausted): rearbitrate over `req`. o is a candidate at lowest priority, and is re-granted with a freshly loaded credit only if no one else requests.
3. `done` = 1 and `credit` > 1: `credit` ← `credit` − 1; grant unchanged.
4. Otherwise: hold.

Rearbitrate:
- If the candidate set is non-empty, load the new winner exactly as in IDLE, staying in OWNED.
- If it is empty: `grant` ← 0, `credit` ← 0, go to IDLE. `ptr` keeps o.

Other rules:
- `weight` changes while a requester is owned have no effect until its next grant.
- Simultaneous `done` and dropped `req[o]`: rule 1 applies. The transfer counts, but there is no further bookkeeping.
- `rst` asserted in any state forces reset values at that edge, regardless of `req` or `done`.

## Timing
- Request-to-grant latency: `req` sampled high at edge k gives `grant` visible after edge k, i.e. 1 cycle from an idle arbiter.
- Handover: `done` with `credit` = 1 at edge k puts the new owner's `grant` valid after edge k, with zero bubble cycles.
- Abandon: `req[o]` low at edge k means the grant changes or clears after edge k.
- Ownership holds exactly `weight` `done` pulses when the owner keeps requesting.
- All outputs are registers; there are no combinational paths from inputs to outputs.
- `grant` is always one-hot or zero. Assert this every cycle.

## Test plan
- Reset then idle:
  - `rst` = 1 for 2 cycles, `req` = 4'b1111 → `grant` = 0, `credit` = 0.
  - After release with `req` = 4'b1111, the first grant is 4'b0001.
- Equal weights:
  - `weight` all 1, `req` = 4'b1111, `done` = 1 every cycle → grants 0001, 0010, 0100, 1000, 0001, …
  - Each grant lasts one cycle, with no gaps.
- Weighted burst:
  - Weights {3,1,2,0}, `req` = 4'b1111, `done` held high → owner sequence 0,0,0,1,2,2,3,0.
  - `credit` counts 3,2,1 for requester 0.
- Abandon mid-burst:
  - Owner 2 with weight 4, `credit` = 3; drop `req[2]` with `done` = 0 and `req[3]` = 1 → next cycle `grant` = 4'b1000, `credit` = `weight[3]`.
  - If no other request is present instead: `grant` = 0, FSM returns to IDLE.
- Sole requester: only `req[1]` high, weight 2, `done` every cycle → `grant` stays 4'b0010 continuously and `credit` reloads 2,1,2,1.
- Reset mid-burst: owner 0 with `credit` = 2, `rst` pulsed for 1 cycle → next cycle all outputs are 0 and the first grant after reset follows `ptr` = N-1 (requester 0 first).

Source files
------------

// File: rtl/weighted_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the weighted round-robin arbiter.
// The requester side drives the master modport and the arbiter uses the slave modport.
interface weighted_rr_arbiter_if #(
  parameter int request_lines = 4,
  parameter int WEIGHT_W      = 4
);
  localparam int IDX_W = $clog2(request_lines);

  logic [request_lines-1:0]          req;
  logic [request_lines*WEIGHT_W-1:0] weight;
  logic                              done;
  logic [request_lines-1:0]          grant;
  logic [IDX_W-1:0]                  grant_idx;
  logic                              grant_valid;
  logic [WEIGHT_W-1:0]               credit;

  modport master (
    output req, weight, done,
    input  grant, grant_idx, grant_valid, credit
  );

  modport slave (
    input  req, weight, done,
    output grant, grant_idx, grant_valid, credit
  );
endinterface

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: the owner keeps a registered one-hot grant for up to
// weight[i] completed transfers, releases early when it drops its request, then priority rotates.
module weighted_rr_arbiter #(
  parameter int request_lines = 4,
  parameter int WEIGHT_W      = 4
) (
  input logic                    clk,
  input logic                    rst,
  weighted_rr_arbiter_if.slave   bus
);
  localparam int N  = request_lines;
  localparam int W  = WEIGHT_W;
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t         state_q,  state_d;
  logic [IW-1:0]  ptr_q,    ptr_d;
  logic [IW-1:0]  idx_q,    idx_d;
  logic [N-1:0]   grant_q,  grant_d;
  logic [W-1:0]   credit_q, credit_d;

  logic [N-1:0]   mask, masked, pick_vec;
  logic [IW-1:0]  win;
  logic           found;
  logic [W-1:0]   win_weight, load_credit;

  // Candidate set is always req: on abandon the owner's bit is already low, and on
  // exhaustion the owner sits at ptr, which the search visits last.
  always_comb begin
    for (int i = 0; i < N; i++) mask[i] = (i > int'(ptr_q));
    masked   = bus.req & mask;
    pick_vec = (|masked) ? masked : bus.req;
    win      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick_vec[i]) win = IW'(i);
    end
    found       = |bus.req;
    win_weight  = bus.weight[int'(win)*W +: W];
    load_credit = (win_weight == '0) ? W'(1) : win_weight;
  end

  always_comb begin
    // NOTE: every next-state variable takes its hold value first so no path infers a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    grant_d  = grant_q;
    credit_d = credit_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = OWNED;
          grant_d  = N'(1) << win;
          idx_d    = win;
          ptr_d    = win;
          credit_d = load_credit;
        end
      end
      OWNED: begin
        if (!bus.req[idx_q] || (bus.done && credit_q == W'(1))) begin
          if (found) begin
            grant_d  = N'(1) << win;
            idx_d    = win;
            ptr_d    = win;
            credit_d = load_credit;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            credit_d = '0;
          end
        end else if (bus.done) begin
          credit_d = credit_q - W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= IW'(N - 1);
      idx_q    <= '0;
      grant_q  <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = |grant_q;
  assign bus.credit      = credit_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
endmodule
